mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Memory-stage load/store unit: responder to the mem_rw / wb_sel control issued by the control unit.
//   Takes the M-stage access (address, store data, funct3), issues one transaction on a valid/ready
//   data bus, extracts and extends load data for the WB_MEM path, and stalls the pipeline until done.
//   Sits between the XM pipeline registers and data memory; load_data feeds the MW register.
// PARAMETERS
//   DATAW  32  data/register width (only 32 supported; strobes are DATAW/8 = 4 bits)
//   MADDRW 32  byte-address width on the data bus
// PORTS
//   clock          in   1       system clock
//   reset          in   1       synchronous, active-high
//   req_valid      in   1       M-stage instruction is a load or store
//   mem_rw         in   1       1 = store, 0 = load
//   funct3         in   3       access size: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0/1/2 (stores)
//   addr           in   MADDRW  byte address (ALU result)
//   wdata          in   DATAW   store data (rs2, after bypass)
//   stall          out  1       freeze PC and F/D/X/M pipeline registers
//   load_valid     out  1       load_data valid; one-cycle pulse
//   load_data      out  DATAW   aligned, sign/zero-extended load result
//   lsu_fault      out  1       misaligned or illegal-size access; one-cycle pulse
//   bus_req_valid  out  1       bus request valid
//   bus_req_ready  in   1       bus accepts request
//   bus_we         out  1       1 = write
//   bus_addr       out  MADDRW  word-aligned address {addr[MADDRW-1:2],2'b00}
//   bus_wstrb      out  4       byte write enables
//   bus_wdata      out  DATAW   lane-replicated store data
//   bus_resp_valid in   1       read data valid (loads only; writes have no response)
//   bus_rdata      in   DATAW   read word
// BEHAVIOUR
//   FSM: IDLE, REQ, WAIT, DONE. Reset -> IDLE.
//   Reset values: stall 0, load_valid 0, load_data 0, lsu_fault 0, bus_req_valid 0, bus_we 0, bus_wstrb 0.
//   IDLE:
//     - req_valid & legal: latch addr/funct3/mem_rw, strobes, data; stall=1 (combinational); -> REQ.
//     - req_valid & illegal: lsu_fault=1 next cycle, no bus transaction, no stall; stay IDLE.
//     - Illegal = load funct3 in {3,6,7}; store funct3 > 2; H with addr[0]=1; W with addr[1:0]!=0.
//   REQ: bus_req_valid=1, stall=1.
//     - Address, we, wstrb and wdata held stable until bus_req_ready.
//     - On ready: store -> DONE; load -> WAIT.
//   WAIT: stall=1; on bus_resp_valid capture the extended data -> DONE.
//   DONE: stall=0; load_valid=1 for loads. Pipeline advances at this edge -> IDLE.
//   Back-to-back requests: new request accepted in the IDLE cycle after DONE.
//   Latency with zero-wait memory: store 3 cycles (stall 2); load 4 cycles (stall 3).
//   Store lanes (o = addr[1:0]):
//     - SB: wstrb = 4'b0001<<o, wdata = {4{wdata[7:0]}}.
//     - SH: wstrb = 4'b0011<<o, wdata = {2{wdata[15:0]}}.
//     - SW: wstrb = 4'hF.
//   Load extract: s = bus_rdata >> (8*o).
//     - LB/LH sign-extend s[7:0]/s[15:0]; LBU/LHU zero-extend; LW passes the word.
//   bus_resp_valid outside WAIT is ignored. Response must arrive >=1 cycle after acceptance.
//   Reset mid-transaction: -> IDLE next edge; bus_req_valid and stall drop. A late response is ignored.
//   req_valid/inputs are sampled only in IDLE; changes during REQ/WAIT/DONE are ignored.
// TESTING
//   LW addr 0x100, ready=1, rdata 0xDEADBEEF after 1 cycle
//     -> stall 3 cycles; load_valid with load_data 0xDEADBEEF; bus_addr 0x100.
//   LB addr 0x103, rdata 0x80FF_0000 -> load_data 0xFFFFFF80. Same with LBU -> 0x00000080.
//   SH addr 0x22, wdata 0x1234ABCD
//     -> bus_we=1, wstrb 4'b1100, wdata 0xABCDABCD, bus_addr 0x20; stall 2 cycles.
//   LW addr 0x102 -> lsu_fault pulse, no bus_req_valid, stall stays 0.
//   bus_req_ready low 5 cycles during SW -> request and payload stable, stall held, completes after ready.
//   reset asserted in WAIT, then stray resp_valid -> IDLE, no load_valid, all outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with valid/ready data bus
module mem_access_unit #(
    parameter int DATAW  = 32,
    parameter int MADDRW = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_rw,
    input  logic [2:0]        funct3,
    input  logic [MADDRW-1:0] addr,
    input  logic [DATAW-1:0]  wdata,
    output logic              stall,
    output logic              load_valid,
    output logic [DATAW-1:0]  load_data,
    output logic              lsu_fault,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic              bus_we,
    output logic [MADDRW-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATAW-1:0]  bus_wdata,
    input  logic              bus_resp_valid,
    input  logic [DATAW-1:0]  bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [MADDRW-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [DATAW-1:0]  wdata_q;
    logic [DATAW-1:0]  load_data_q;
    logic              fault_q;

    logic              legal;
    logic              accept;
    logic              reject;
    logic [3:0]        wstrb_d;
    logic [DATAW-1:0]  wdata_d;
    logic [DATAW-1:0]  shifted;
    logic [DATAW-1:0]  extracted;

    // Legality: size codes per direction, then natural alignment for H and W.
    always_comb begin
        legal = 1'b1;
        if (mem_rw) begin
            if (funct3 > 3'd2) legal = 1'b0;
        end else begin
            if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) legal = 1'b0;
        end
        if (funct3[1:0] == 2'd1 && addr[0]) legal = 1'b0;
        if (funct3[1:0] == 2'd2 && addr[1:0] != 2'b00) legal = 1'b0;
    end

    assign accept = (state == IDLE) && req_valid && legal;
    assign reject = (state == IDLE) && req_valid && !legal;

    // Store lane steering: replicate the datum into every lane, enable only the target bytes.
    always_comb begin
        wstrb_d = 4'b0000;
        wdata_d = wdata;
        if (mem_rw) begin
            case (funct3[1:0])
                2'd0: begin
                    wstrb_d = 4'b0001 << addr[1:0];
                    wdata_d = {4{wdata[7:0]}};
                end
                2'd1: begin
                    wstrb_d = 4'b0011 << addr[1:0];
                    wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                    wstrb_d = 4'hF;
                    wdata_d = wdata;
                end
            endcase
        end
    end

    // Load extraction: bring the addressed byte/half to bit 0, then extend by funct3.
    always_comb begin
        shifted = bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    extracted = {{24{shifted[7]}}, shifted[7:0]};
            3'd1:    extracted = {{16{shifted[15]}}, shifted[15:0]};
            3'd4:    extracted = {24'd0, shifted[7:0]};
            3'd5:    extracted = {16'd0, shifted[15:0]};
            default: extracted = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state and control outputs; IDLE stalls as soon as a legal access is seen.
    always_comb begin
        next_state    = state;
        stall         = 1'b0;
        bus_req_valid = 1'b0;
        load_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                stall         = 1'b1;
                bus_req_valid = 1'b1;
                if (bus_req_ready) next_state = we_q ? DONE : WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (bus_resp_valid) next_state = DONE;
            end
            DONE: begin
                load_valid = !we_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request payload latched on acceptance and held until the bus takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            addr_q  <= '0;
            wstrb_q <= 4'b0000;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= mem_rw;
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            addr_q  <= {addr[MADDRW-1:2], 2'b00};
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

    // Load result captured with the response; fault pulse one cycle after a rejected access.
    always_ff @(posedge clock) begin
        if (reset) begin
            load_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= reject;
            if (state == WAIT && bus_resp_valid) load_data_q <= extracted;
        end
    end

    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wstrb = wstrb_q;
    assign bus_wdata = wdata_q;
    assign load_data = load_data_q;
    assign lsu_fault = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        mem_rw;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        lsu_fault;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    int tests_run;
    int tests_failed;

    mem_access_unit #(.DATAW(32), .MADDRW(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .mem_rw         (mem_rw),
        .funct3         (funct3),
        .addr           (addr),
        .wdata          (wdata),
        .stall          (stall),
        .load_valid     (load_valid),
        .load_data      (load_data),
        .lsu_fault      (lsu_fault),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wstrb      (bus_wstrb),
        .bus_wdata      (bus_wdata),
        .bus_resp_valid (bus_resp_valid),
        .bus_rdata      (bus_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request in IDLE and let combinational outputs settle.
    task automatic present(input logic rw, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
        req_valid = 1'b1;
        mem_rw    = rw;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        #1;
    endtask

    // Zero-wait load: stall in IDLE, REQ and WAIT, then load_valid in DONE.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
        present(1'b0, f3, a, 32'h0);
        check({tag, " stall idle"}, stall, 1);
        tick();
        req_valid     = 1'b0;
        addr          = 32'hFFFF_FFFF;
        bus_req_ready = 1'b1;
        #1;
        check({tag, " req_valid"}, bus_req_valid, 1);
        check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
        check({tag, " bus_we"}, bus_we, 0);
        check({tag, " stall req"}, stall, 1);
        tick();
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b1;
        bus_rdata      = rdata;
        #1;
        check({tag, " req dropped"}, bus_req_valid, 0);
        check({tag, " stall wait"}, stall, 1);
        tick();
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'h0;
        #1;
        check({tag, " stall done"}, stall, 0);
        check({tag, " load_valid"}, load_valid, 1);
        check({tag, " load_data"}, load_data, exp);
        tick();
        check({tag, " load_valid pulse"}, load_valid, 0);
    endtask

    // Zero-wait store: stall in IDLE and REQ only.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_strb,
                            input logic [31:0] exp_data);
        present(1'b1, f3, a, d);
        check({tag, " stall idle"}, stall, 1);
        tick();
        req_valid     = 1'b0;
        bus_req_ready = 1'b1;
        #1;
        check({tag, " req_valid"}, bus_req_valid, 1);
        check({tag, " bus_we"}, bus_we, 1);
        check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
        check({tag, " wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_strb});
        check({tag, " wdata"}, bus_wdata, exp_data);
        check({tag, " stall req"}, stall, 1);
        tick();
        bus_req_ready = 1'b0;
        #1;
        check({tag, " stall done"}, stall, 0);
        check({tag, " no load_valid"}, load_valid, 0);
        check({tag, " req dropped"}, bus_req_valid, 0);
        tick();
    endtask

    task automatic do_fault(input string tag, input logic rw, input logic [2:0] f3,
                            input logic [31:0] a);
        present(rw, f3, a, 32'h5555_AAAA);
        check({tag, " no stall"}, stall, 0);
        tick();
        req_valid = 1'b0;
        #1;
        check({tag, " fault"}, lsu_fault, 1);
        check({tag, " no req"}, bus_req_valid, 0);
        check({tag, " no stall after"}, stall, 0);
        tick();
        check({tag, " fault pulse"}, lsu_fault, 0);
        check({tag, " still idle"}, bus_req_valid, 0);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        reset          = 1'b1;
        req_valid      = 1'b0;
        mem_rw         = 1'b0;
        funct3         = 3'd0;
        addr           = 32'h0;
        wdata          = 32'h0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_rdata      = 32'h0;
        tick();
        tick();
        check("rst stall", stall, 0);
        check("rst load_valid", load_valid, 0);
        check("rst load_data", load_data, 0);
        check("rst fault", lsu_fault, 0);
        check("rst req_valid", bus_req_valid, 0);
        check("rst we", bus_we, 0);
        check("rst wstrb", {28'd0, bus_wstrb}, 0);
        reset = 1'b0;
        tick();

        do_load("LW100", 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        do_load("LB103", 3'd0, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("LBU103", 3'd4, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        do_load("LH102", 3'd1, 32'h0000_0102, 32'h8001_2345, 32'hFFFF_8001);
        do_load("LHU102", 3'd5, 32'h0000_0102, 32'h8001_2345, 32'h0000_8001);
        do_load("LB101", 3'd0, 32'h0000_0101, 32'h1122_7F44, 32'h0000_007F);

        do_store("SH22", 3'd1, 32'h0000_0022, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("SB101", 3'd0, 32'h0000_0101, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
        do_store("SW40", 3'd2, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        do_fault("LW102", 1'b0, 3'd2, 32'h0000_0102);
        do_fault("LH101", 1'b0, 3'd1, 32'h0000_0101);
        do_fault("LD3", 1'b0, 3'd3, 32'h0000_0100);
        do_fault("SBU4", 1'b1, 3'd4, 32'h0000_0100);

        // SW with the bus holding off for five cycles.
        present(1'b1, 3'd2, 32'h0000_0080, 32'h0BAD_F00D);
        tick();
        req_valid = 1'b0;
        wdata     = 32'h0;
        addr      = 32'h0000_0FFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("SWwait req_valid", bus_req_valid, 1);
            check("SWwait addr", bus_addr, 32'h0000_0080);
            check("SWwait wdata", bus_wdata, 32'h0BAD_F00D);
            check("SWwait wstrb", {28'd0, bus_wstrb}, 32'hF);
            check("SWwait we", bus_we, 1);
            check("SWwait stall", stall, 1);
            tick();
        end
        bus_req_ready = 1'b1;
        #1;
        check("SWwait still req", bus_req_valid, 1);
        tick();
        bus_req_ready = 1'b0;
        #1;
        check("SWwait done stall", stall, 0);
        check("SWwait done req", bus_req_valid, 0);
        tick();

        // Reset while waiting for load data, then a stray response.
        present(1'b0, 3'd2, 32'h0000_0200, 32'h0);
        tick();
        req_valid     = 1'b0;
        bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
        #1;
        check("RSTwait stall", stall, 1);
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        bus_resp_valid = 1'b1;
        bus_rdata      = 32'h1357_9BDF;
        #1;
        check("RSTwait stall drop", stall, 0);
        check("RSTwait req drop", bus_req_valid, 0);
        tick();
        bus_resp_valid = 1'b0;
        #1;
        check("RSTwait no load_valid", load_valid, 0);
        check("RSTwait load_data", load_data, 0);
        check("RSTwait stall", stall, 0);
        check("RSTwait fault", lsu_fault, 0);
        check("RSTwait we", bus_we, 0);
        check("RSTwait wstrb", {28'd0, bus_wstrb}, 0);
        tick();
        check("RSTwait no late valid", load_valid, 0);

        // Unit still works after the mid-transaction reset.
        do_load("LWpost", 3'd2, 32'h0000_0300, 32'hA5A5_5A5A, 32'hA5A5_5A5A);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
